// File: rtl/command_tx.sv
// command_tx: maps a 2-bit command to an opcode and sends it as an async serial frame.
// Optional even-parity bit after the data byte when CMD_TX_PARITY_EN is defined.
module command_tx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200,
   parameter logic [7:0]  CMD0     = 8'h41,
   parameter logic [7:0]  CMD1     = 8'h53,
   parameter logic [7:0]  CMD2     = 8'h54,
   parameter logic [7:0]  CMD3     = 8'h52
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] command,
   input  logic       start,
   output logic       ready_command,
   output logic       tx,
   output logic       tx_done
);
   localparam int unsigned CPB = CLK_FREQ / BAUD;
   localparam int unsigned CW  = (CPB > 2) ? $clog2(CPB) : 1;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef CMD_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   logic [2:0]    r_state;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_opcode;
   logic          r_tx;
   logic          r_ready;
   logic          r_done;
   logic          w_bit_end;
   logic [2:0]    w_next_idx;
   logic [7:0]    w_opcode;
   assign w_bit_end  = r_baud_cnt == CW'(CPB - 1);
   assign w_next_idx = r_bit_idx + 3'd1;
   assign w_opcode   = command[1] ? (command[0] ? CMD3 : CMD2) : (command[0] ? CMD1 : CMD0);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_opcode   <= '0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            if (start) begin
               r_opcode   <= w_opcode;
               r_state    <= S_START;
               r_tx       <= 1'b0;
               r_ready    <= 1'b0;
               r_baud_cnt <= '0;
               r_bit_idx  <= '0;
            end
         end else begin
            r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            // every state change happens on the last cycle of a bit period
            if (w_bit_end) begin
               case (r_state)
                  S_START: begin
                     r_state <= S_DATA;
                     r_tx    <= r_opcode[0];
                  end
                  S_DATA: begin
                     if (r_bit_idx == 3'd7) begin
`ifdef CMD_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_tx    <= ^r_opcode;
`else
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
`endif
                     end else begin
                        r_bit_idx <= w_next_idx;
                        r_tx      <= r_opcode[w_next_idx];
                     end
                  end
`ifdef CMD_TX_PARITY_EN
                  S_PARITY: begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end
`endif
                  S_STOP: begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                     r_ready <= 1'b1;
                     r_done  <= 1'b1;
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                     r_ready <= 1'b1;
                  end
               endcase
            end
         end
      end
   end
   assign ready_command = r_ready;
   assign tx            = r_tx;
   assign tx_done       = r_done;
endmodule

// File: tb/tb_command_tx.sv
// tb_command_tx: directed vector table plus hand-written sequences for command_tx.
module tb_command_tx;
   localparam int CPB = 10;
`ifdef CMD_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   typedef struct { logic [1:0] cmd; logic [7:0] op; } vec_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [1:0] command = 2'b00;
   logic       ready_command, tx, tx_done;
   int         n_tests = 0;
   int         n_fail = 0;
   vec_t       vecs[4];
   always #5 clk = ~clk;
   command_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) dut (
      .clk(clk), .rst(rst), .command(command), .start(start),
      .ready_command(ready_command), .tx(tx), .tx_done(tx_done)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // one full frame from the accept edge; pulse_at injects an ignored start mid-frame
   task automatic frame(input logic [1:0] cmd, input logic [7:0] op, input bit hold, input int pulse_at);
      logic [10:0] fr;
      int early;
`ifdef CMD_TX_PARITY_EN
      fr = {1'b1, ^op, op, 1'b0};
`else
      fr = {2'b11, op, 1'b0};
`endif
      command = cmd;
      start = 1'b1;
      tick;
      if (!hold) start = 1'b0;
      check("accept_tx", tx, 0);
      check("accept_ready", ready_command, 0);
      early = 0;
      for (int j = 1; j <= NB * CPB; j++) begin
         if (j == pulse_at) begin
            command = 2'b11;
            start = 1'b1;
         end
         tick;
         if (j == pulse_at) begin
            start = 1'b0;
            command = cmd;
         end
         if (j < NB * CPB && tx_done) early++;
         if (j % CPB == 5) begin
            check($sformatf("bit%0d_op%0h", j / CPB, op), tx, fr[j / CPB]);
            check("busy_ready", ready_command, 0);
         end
      end
      check("end_ready", ready_command, 1);
      check("end_done", tx_done, 1);
      check("end_tx", tx, 1);
      check("no_early_done", early, 0);
      if (!hold) begin
         tick;
         check("done_pulse_len", tx_done, 0);
         check("idle_ready", ready_command, 1);
      end
   endtask
   initial begin
      int changes;
      vecs[0] = '{2'b00, 8'h41};
      vecs[1] = '{2'b01, 8'h53};
      vecs[2] = '{2'b10, 8'h54};
      vecs[3] = '{2'b11, 8'h52};
      repeat (5) tick;
      check("rst_tx", tx, 1);
      check("rst_ready", ready_command, 1);
      check("rst_done", tx_done, 0);
      rst = 1'b1;
      changes = 0;
      repeat (20) begin
         tick;
         if (tx !== 1'b1 || ready_command !== 1'b1 || tx_done !== 1'b0) changes++;
      end
      check("idle_stable", changes, 0);
      for (int i = 0; i < 4; i++) begin
         frame(vecs[i].cmd, vecs[i].op, 1'b0, -1);
         repeat (3) tick;
      end
      frame(2'b01, 8'h53, 1'b0, 35);
      repeat (3) tick;
      frame(2'b00, 8'h41, 1'b1, -1);
      frame(2'b00, 8'h41, 1'b0, -1);
      repeat (3) tick;
      command = 2'b01;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (44) tick;
      check("pre_abort_busy", ready_command, 0);
      rst = 1'b0;
      #1;
      check("abort_tx", tx, 1);
      check("abort_ready", ready_command, 1);
      check("abort_done", tx_done, 0);
      repeat (3) tick;
      rst = 1'b1;
      changes = 0;
      repeat (120) begin
         tick;
         if (tx_done !== 1'b0 || tx !== 1'b1) changes++;
      end
      check("no_done_after_abort", changes, 0);
      frame(2'b10, 8'h54, 1'b0, -1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
